// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode/writeback side of the register scoreboard.
//   master : decode stage (drives decoded fields, wb address, flush;
//            receives stall/issue and the tracking status)
//   slave  : reg_scoreboard
interface reg_scoreboard_if #(
  parameter int NREG          = 32,
  parameter int REGADDR_WIDTH = 5,
  parameter int MAX_INFLIGHT  = 4
);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  logic                     id_valid;
  logic [REGADDR_WIDTH-1:0] id_rs;
  logic [REGADDR_WIDTH-1:0] id_rt;
  logic                     id_uses_rs;
  logic                     id_uses_rt;
  logic [REGADDR_WIDTH-1:0] id_dest;
  logic [REGADDR_WIDTH-1:0] wb_addr;
  logic                     flush;
  logic                     stall;
  logic                     issue;
  logic [NREG-1:0]          busy;
  logic [IW-1:0]            inflight;
  logic                     err_underflow;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, wb_addr, flush,
    input  stall, issue, busy, inflight, err_underflow
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, wb_addr, flush,
    output stall, issue, busy, inflight, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-file interlock for the in-order pipeline.
// Keeps a pending-write counter per architectural register (r0 untracked)
// plus a total in-flight count, stalls decode on operand hazards or when
// tracking capacity is exhausted, and releases on writeback retirement.
// Ports:
//   clk, rst : clock, async active-high reset
//   sb       : reg_scoreboard_if.slave (decode fields, wb address, flush in;
//              stall, issue, busy, inflight, err_underflow out)
module reg_scoreboard #(
  parameter int NREG          = 32,
  parameter int REGADDR_WIDTH = 5,
  parameter int CNT_WIDTH     = 2,
  parameter int MAX_INFLIGHT  = 4,
  parameter int WB_BYPASS     = 1
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb
);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [NREG-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0]                  inflight_q, inflight_d;
  logic                           err_q;

  logic [CNT_WIDTH-1:0] rs_cnt, rt_cnt, dst_cnt, wb_cnt;
  logic wb_hit, rs_raw, rt_raw, cap_hz, stall, issue, inc, dec, underflow;

  assign rs_cnt  = cnt_q[sb.id_rs];
  assign rt_cnt  = cnt_q[sb.id_rt];
  assign dst_cnt = cnt_q[sb.id_dest];
  assign wb_cnt  = cnt_q[sb.wb_addr];

  // A real retirement this cycle (r0 and empty counters don't count).
  assign wb_hit    = (sb.wb_addr != '0) && (wb_cnt != '0);
  assign underflow = (sb.wb_addr != '0) && (wb_cnt == '0);

  // eff(r) != 0 reduces to: cnt != 0, unless the bypass eats the last pending write.
  assign rs_raw = sb.id_uses_rs && (sb.id_rs != '0) && (rs_cnt != '0) &&
                  !((WB_BYPASS != 0) && (sb.wb_addr == sb.id_rs) && (rs_cnt == CNT_ONE));
  assign rt_raw = sb.id_uses_rt && (sb.id_rt != '0) && (rt_cnt != '0) &&
                  !((WB_BYPASS != 0) && (sb.wb_addr == sb.id_rt) && (rt_cnt == CNT_ONE));

  // Counter saturation gets no writeback credit; the global limit does.
  assign cap_hz = ((sb.id_dest != '0) && (dst_cnt == CNT_MAX)) ||
                  ((inflight_q == IW'(MAX_INFLIGHT)) && !wb_hit);

  assign stall = sb.id_valid && (rs_raw || rt_raw || cap_hz);
  assign issue = sb.id_valid && !stall;
  assign inc   = issue && (sb.id_dest != '0);
  assign dec   = wb_hit;

  always_comb begin
    cnt_d = cnt_q;
    cnt_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      if (inc && (sb.id_dest == REGADDR_WIDTH'(r)) &&
          !(dec && (sb.wb_addr == REGADDR_WIDTH'(r))))
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      else if (dec && (sb.wb_addr == REGADDR_WIDTH'(r)) &&
               !(inc && (sb.id_dest == REGADDR_WIDTH'(r))))
        cnt_d[r] = cnt_q[r] - CNT_ONE;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (inc && !dec)      inflight_d = inflight_q + IW'(1);
    else if (dec && !inc) inflight_d = inflight_q - IW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else if (sb.flush) begin
      // Flush drops all tracking but keeps the sticky error.
      cnt_q      <= '0;
      inflight_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      if (underflow) err_q <= 1'b1;
    end
  end

  always_comb begin
    sb.busy = '0;
    for (int r = 1; r < NREG; r++) sb.busy[r] = (cnt_q[r] != '0);
  end

  assign sb.stall         = stall;
  assign sb.issue         = issue;
  assign sb.inflight      = inflight_q;
  assign sb.err_underflow = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  logic clk, rst;
  logic       id_valid, id_uses_rs, id_uses_rt, flush;
  logic [4:0] id_rs, id_rt, id_dest, wb_addr;
  int checks = 0;
  int errors = 0;

  reg_scoreboard_if #(.NREG(32), .REGADDR_WIDTH(5), .MAX_INFLIGHT(4)) ifa ();
  reg_scoreboard_if #(.NREG(32), .REGADDR_WIDTH(5), .MAX_INFLIGHT(4)) ifb ();

  assign ifa.id_valid = id_valid;     assign ifb.id_valid = id_valid;
  assign ifa.id_rs = id_rs;           assign ifb.id_rs = id_rs;
  assign ifa.id_rt = id_rt;           assign ifb.id_rt = id_rt;
  assign ifa.id_uses_rs = id_uses_rs; assign ifb.id_uses_rs = id_uses_rs;
  assign ifa.id_uses_rt = id_uses_rt; assign ifb.id_uses_rt = id_uses_rt;
  assign ifa.id_dest = id_dest;       assign ifb.id_dest = id_dest;
  assign ifa.wb_addr = wb_addr;       assign ifb.wb_addr = wb_addr;
  assign ifa.flush = flush;           assign ifb.flush = flush;

  reg_scoreboard #(.WB_BYPASS(1)) u_a (.clk(clk), .rst(rst), .sb(ifa.slave));
  reg_scoreboard #(.WB_BYPASS(0)) u_b (.clk(clk), .rst(rst), .sb(ifb.slave));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; flush = 0;
    id_rs = 0; id_rt = 0; id_dest = 0; wb_addr = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    #12;
    chk("rst_busy",     ifa.busy, 32'h0);
    chk("rst_inflight", ifa.inflight, 0);
    chk("rst_err",      ifa.err_underflow, 0);
    chk("rst_stall",    ifa.stall, 0);
    rst = 0;
    cyc();

    // 1/2: RAW on r5, bypass (a) vs no bypass (b)
    id_valid = 1; id_dest = 5; #1;
    chk("s1_issue_a", ifa.issue, 1);
    chk("s1_issue_b", ifb.issue, 1);
    cyc();
    id_dest = 0; id_uses_rs = 1; id_rs = 5; #1;
    chk("s1_busy5", ifa.busy[5], 1);
    chk("s1_inflight", ifa.inflight, 1);
    for (int i = 0; i < 3; i++) begin
      chk("s1_hold_a", ifa.stall, 1);
      chk("s1_hold_b", ifb.stall, 1);
      cyc();
    end
    wb_addr = 5; #1;
    chk("s1_wb_stall_a", ifa.stall, 0);
    chk("s1_wb_issue_a", ifa.issue, 1);
    chk("s2_wb_stall_b", ifb.stall, 1);
    cyc();
    wb_addr = 0; #1;
    chk("s1_busy5_clr", ifa.busy[5], 0);
    chk("s2_busy5_clr", ifb.busy[5], 0);
    chk("s2_stall_b", ifb.stall, 0);
    chk("s2_issue_b", ifb.issue, 1);
    cyc();
    idle(); #1;
    chk("s2_inflight_b", ifb.inflight, 0);
    // r0 as a source never stalls
    id_valid = 1; id_uses_rs = 1; id_rs = 0; id_uses_rt = 1; id_rt = 0; #1;
    chk("r0_nostall", ifa.stall, 0);
    idle();

    // 3: global capacity
    for (int d = 1; d <= 4; d++) begin
      id_valid = 1; id_dest = 5'(d); #1;
      chk("s3_fill_issue", ifa.issue, 1);
      cyc();
    end
    chk("s3_inflight4", ifa.inflight, 4);
    id_dest = 6; #1;
    chk("s3_full_stall", ifa.stall, 1);
    cyc();
    chk("s3_full_stall2", ifa.stall, 1);
    wb_addr = 2; #1;
    chk("s3_wb_issue_a", ifa.issue, 1);
    chk("s3_wb_issue_b", ifb.issue, 1);
    cyc();
    idle(); #1;
    chk("s3_inflight_after", ifa.inflight, 4);
    chk("s3_busy", ifa.busy, 32'h0000_005A);
    flush = 1;
    cyc();
    flush = 0; #1;
    chk("s3_flush_inflight", ifa.inflight, 0);

    // 4: per-register counter saturation
    for (int i = 0; i < 3; i++) begin
      id_valid = 1; id_dest = 7; #1;
      chk("s4_fill_issue", ifa.issue, 1);
      cyc();
    end
    chk("s4_inflight3", ifa.inflight, 3);
    chk("s4_sat_stall", ifa.stall, 1);
    cyc();
    wb_addr = 7; #1;
    chk("s4_sat_wb_stall", ifa.stall, 1);
    cyc();
    wb_addr = 0; #1;
    chk("s4_inflight2", ifa.inflight, 2);
    chk("s4_after_issue", ifa.issue, 1);
    cyc();
    idle(); #1;
    chk("s4_inflight3b", ifa.inflight, 3);
    flush = 1;
    cyc();
    flush = 0;

    // 5: same-cycle inc/dec on the same register
    id_valid = 1; id_dest = 9;
    cyc();
    wb_addr = 9; #1;
    chk("s5_issue", ifa.issue, 1);
    cyc();
    idle(); #1;
    chk("s5_busy9", ifa.busy[9], 1);
    chk("s5_inflight", ifa.inflight, 1);
    wb_addr = 9;
    cyc();
    idle(); #1;
    chk("s5_drained", ifa.inflight, 0);
    chk("s5_noerr", ifa.err_underflow, 0);

    // 6: underflow, flush, async reset
    wb_addr = 12;
    cyc();
    idle(); #1;
    chk("s6_err", ifa.err_underflow, 1);
    chk("s6_busy", ifa.busy, 32'h0);
    id_valid = 1; id_dest = 3;
    cyc();
    idle(); #1;
    chk("s6_err_sticky", ifa.err_underflow, 1);
    chk("s6_busy3", ifa.busy, 32'h0000_0008);
    flush = 1; id_valid = 1; id_dest = 8; wb_addr = 3;
    cyc();
    idle(); #1;
    chk("s6_flush_busy", ifa.busy, 32'h0);
    chk("s6_flush_inflight", ifa.inflight, 0);
    chk("s6_flush_err", ifa.err_underflow, 1);
    #1 rst = 1;
    #1;
    chk("s6_async_err", ifa.err_underflow, 0);
    #1 rst = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Register-file interlock controller for the in-order MIPS pipeline. It tracks pending writebacks per architectural register and per-pipeline totals. It stalls the decode stage when an operand or destination hazard exists, and releases the stall when the matching writeback retires. It sits beside stage_id: it consumes the decoded rs/rt/destination fields and the writeback-stage register address, and drives the decode stall/issue signals.

Parameters:
NREG, 32, number of architectural registers; register 0 is never tracked.
REGADDR_WIDTH, 5, register address width.
CNT_WIDTH, 2, width of each per-register pending counter; CNT_MAX = 2^CNT_WIDTH-1.
MAX_INFLIGHT, 4, maximum total outstanding writes across all registers.
WB_BYPASS, 1, when 1, a writeback in the same cycle releases a hazard on that register.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  decode stage holds a valid instruction
id_rs  in  REGADDR_WIDTH  source register 1 address
id_rt  in  REGADDR_WIDTH  source register 2 address
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_dest  in  REGADDR_WIDTH  destination register; 0 = no write
wb_addr  in  REGADDR_WIDTH  register being written back this cycle; 0 = none
flush  in  1  pipeline flush; discards all tracking
stall  out  1  decode must hold (combinational from state and inputs)
issue  out  1  id_valid && !stall
busy  out  NREG  bit i = counter i nonzero (registered state view); bit 0 always 0
inflight  out  $clog2(MAX_INFLIGHT+1)  total outstanding writes
err_underflow  out  1  sticky: a writeback arrived for a register with counter 0

Behaviour:
- Reset (async, rst=1): all counters 0, inflight=0, err_underflow=0, busy=0. Because stall is combinational, stall=0 while id_valid=0.
- Effective count eff(r) = cnt[r] - (WB_BYPASS && wb_addr==r && r!=0 && cnt[r]!=0 ? 1 : 0).
- Raw hazard:
  - (id_uses_rs && id_rs!=0 && eff(id_rs)!=0), or
  - (id_uses_rt && id_rt!=0 && eff(id_rt)!=0).
- Capacity hazard:
  - id_dest!=0 && cnt[id_dest]==CNT_MAX (no WB_BYPASS credit), or
  - inflight==MAX_INFLIGHT && !(wb_addr!=0 && cnt[wb_addr]!=0).
- stall = id_valid && (raw hazard || capacity hazard). stall=0 whenever id_valid=0.
- Clock edge, no flush:
  - inc = issue && id_dest!=0 → cnt[id_dest]+1, inflight+1.
  - dec = wb_addr!=0 && cnt[wb_addr]!=0 → cnt[wb_addr]-1, inflight-1.
  - inc and dec on the same register: net unchanged. On different registers: both apply.
  - wb_addr!=0 with cnt[wb_addr]==0: no change, err_underflow set to 1 and held until reset.
- Flush (flush=1 at edge): all counters and inflight cleared. issue/wb in the same cycle are ignored for state. err_underflow is unaffected. stall is still computed combinationally that cycle.
- Writes to register 0 (id_dest=0 or wb_addr=0) never touch state.
- Reset asserted mid-operation clears everything immediately, independent of clk.
- Latency: an issued write is visible in busy/stall on the next cycle. A retiring writeback clears the stall in the same cycle (WB_BYPASS=1) or the next cycle (WB_BYPASS=0).

Test Plan:
1. Reset, then issue ADDIU dest=5 (id_dest=5); next cycle id_rs=5, id_uses_rs=1 → stall=1, busy[5]=1, inflight=1. Hold 3 cycles, then wb_addr=5 → same cycle stall=0, issue=1; next cycle busy[5]=0.
2. WB_BYPASS=0 variant of scenario 1 → stall stays 1 in the wb cycle and drops the following cycle.
3. Issue 4 independent writes (dest 1,2,3,4) → inflight=4. A 5th instruction with dest=6 → stall=1 until any wb_addr in {1..4} arrives, then issue=1 the same cycle.
4. Issue dest=7 three times (CNT_WIDTH=2, no reads) → cnt[7]=3. A 4th dest=7 → stall=1. In the same cycle a wb_addr=7 issue still stalls; the next cycle it issues.
5. Same-cycle issue dest=9 and wb_addr=9 with cnt[9]=1 → cnt[9] stays 1, inflight unchanged.
6. wb_addr=12 with cnt[12]=0 → err_underflow=1 sticky, state unchanged. flush with busy nonzero → busy=0, inflight=0 next cycle. Async rst pulse mid-cycle → err_underflow=0 immediately.
